// File: rtl/prog_mem_arbiter_pkg.sv
// Shared types and constants for the program-memory arbiter.
// Holds the FSM state encoding, default address window and port ids.
package prog_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP,
        ERR
    } state_t;

    localparam logic [31:0] DEF_BASE  = 32'h0000_1030;
    localparam logic [31:0] DEF_LIMIT = 32'h0000_142F;

    localparam int OFF_W = 10;
    localparam int CNT_W = 4;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_L = 1'b1;

endpackage

// File: rtl/prog_mem_arbiter_range_check.sv
// Combinational window check for the arbitration-selected address.
// Ports: addr_i in; in_range_o (BASE..LIMIT inclusive), off_o = addr-BASE.
module prog_range_check
    import prog_mem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE  = DEF_BASE,
    parameter logic [31:0] LIMIT = DEF_LIMIT
) (
    input  logic [31:0]      addr_i,
    output logic             in_range_o,
    output logic [OFF_W-1:0] off_o
);

    assign in_range_o = (addr_i >= BASE) && (addr_i <= LIMIT);

    // Only the low bits of the difference reach the memory, and the
    // low bits of a subtraction depend only on the operands' low bits.
    assign off_o = addr_i[OFF_W-1:0] - BASE[OFF_W-1:0];

endmodule

// File: rtl/prog_mem_arbiter.sv
// Two-port (fetch / loader) arbiter in front of a single program memory.
// Ports: F_* fetch (read-only), L_* loader (read/write), MEM_* memory side.
module prog_mem_arbiter
    import prog_mem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE        = DEF_BASE,
    parameter logic [31:0] LIMIT       = DEF_LIMIT,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             F_REQ,
    input  logic [31:0]      F_ADDR,
    output logic             F_GNT,
    output logic             F_VALID,
    output logic             F_ERR,
    output logic [31:0]      F_RDATA,
    input  logic             L_REQ,
    input  logic             L_WE,
    input  logic [31:0]      L_ADDR,
    input  logic [31:0]      L_WDATA,
    output logic             L_GNT,
    output logic             L_VALID,
    output logic             L_ERR,
    output logic [31:0]      L_RDATA,
    output logic             CS_P,
    output logic             MEM_WE,
    output logic [OFF_W-1:0] MEM_ADDR,
    output logic [31:0]      MEM_WDATA,
    input  logic [31:0]      MEM_RDATA
);

    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [OFF_W-1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              f_gnt_q, f_gnt_d, l_gnt_q, l_gnt_d;
    logic              f_val_q, f_val_d, l_val_q, l_val_d;
    logic              f_err_q, f_err_d, l_err_q, l_err_d;
    logic [31:0]       f_rd_q, f_rd_d, l_rd_q, l_rd_d;
    logic              cs_q, cs_d, mwe_q, mwe_d;

    logic              grant_f, grant_l;
    logic [31:0]       sel_addr;
    logic              in_range;
    logic [OFF_W-1:0]  sel_off;

    // Round-robin: on contention the port not granted last wins.
    assign grant_f  = F_REQ & (~L_REQ | (last_q == PORT_L));
    assign grant_l  = L_REQ & ~grant_f;
    assign sel_addr = grant_l ? L_ADDR : F_ADDR;

    prog_range_check #(
        .BASE  (BASE),
        .LIMIT (LIMIT)
    ) u_range (
        .addr_i     (sel_addr),
        .in_range_o (in_range),
        .off_o      (sel_off)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f_gnt_d = 1'b0;
        l_gnt_d = 1'b0;
        f_val_d = 1'b0;
        l_val_d = 1'b0;
        f_err_d = 1'b0;
        l_err_d = 1'b0;
        f_rd_d  = f_rd_q;
        l_rd_d  = l_rd_q;
        // Memory strobes are registered one cycle behind the state, so
        // the grant cycle precedes the first strobed access cycle.
        cs_d    = (state_q == ACCESS);
        mwe_d   = cs_d & we_q;
        unique case (state_q)
            IDLE: begin
                if (F_REQ | L_REQ) begin
                    port_d  = grant_l ? PORT_L : PORT_F;
                    last_d  = grant_l ? PORT_L : PORT_F;
                    f_gnt_d = grant_f;
                    l_gnt_d = grant_l;
                    we_d    = grant_l & L_WE;
                    addr_d  = sel_off;
                    wdata_d = grant_l ? L_WDATA : 32'h0;
                    cnt_d   = WAIT_LD;
                    state_d = in_range ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // MEM_RDATA belongs to the last strobed cycle, i.e. now.
                if (port_q == PORT_L) begin
                    l_val_d = 1'b1;
                    l_rd_d  = MEM_RDATA;
                end else begin
                    f_val_d = 1'b1;
                    f_rd_d  = MEM_RDATA;
                end
                state_d = IDLE;
            end
            ERR: begin
                if (port_q == PORT_L) begin
                    l_val_d = 1'b1;
                    l_err_d = 1'b1;
                end else begin
                    f_val_d = 1'b1;
                    f_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= PORT_L;
            port_q  <= PORT_F;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f_gnt_q <= 1'b0;
            l_gnt_q <= 1'b0;
            f_val_q <= 1'b0;
            l_val_q <= 1'b0;
            f_err_q <= 1'b0;
            l_err_q <= 1'b0;
            f_rd_q  <= '0;
            l_rd_q  <= '0;
            cs_q    <= 1'b0;
            mwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f_gnt_q <= f_gnt_d;
            l_gnt_q <= l_gnt_d;
            f_val_q <= f_val_d;
            l_val_q <= l_val_d;
            f_err_q <= f_err_d;
            l_err_q <= l_err_d;
            f_rd_q  <= f_rd_d;
            l_rd_q  <= l_rd_d;
            cs_q    <= cs_d;
            mwe_q   <= mwe_d;
        end
    end

    assign F_GNT     = f_gnt_q;
    assign L_GNT     = l_gnt_q;
    assign F_VALID   = f_val_q;
    assign L_VALID   = l_val_q;
    assign F_ERR     = f_err_q;
    assign L_ERR     = l_err_q;
    assign F_RDATA   = f_rd_q;
    assign L_RDATA   = l_rd_q;
    assign CS_P      = cs_q;
    assign MEM_WE    = mwe_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;

endmodule
